// File: rtl/ptn_seq_ram_if.sv
// Pattern sequencer RAM bus: host read/write port plus playback control
// and playback output, bundled for connection between bench and design.
interface ptn_seq_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // Host port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Playback control
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] seg_start;
    logic [ADDR_W-1:0] seg_end;
    logic              tick;

    // Playback output
    logic              busy;
    logic              ptn_valid;
    logic [DATA_W-1:0] ptn_data;
    logic [ADDR_W-1:0] ptn_addr;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output start, stop, loop_en, seg_start, seg_end, tick,
        input  rd_data, busy, ptn_valid, ptn_data, ptn_addr, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  start, stop, loop_en, seg_start, seg_end, tick,
        output rd_data, busy, ptn_valid, ptn_data, ptn_addr, done
    );
endinterface

// File: rtl/ptn_seq_ram.sv
// Pattern sequencer: a 2**ADDR_W x DATA_W RAM with a write-first host port
// and a read-first playback port that streams a segment [seg_start..seg_end]
// (wrapping modulo depth) one word per tick, one-shot or looped.
module ptn_seq_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    ptn_seq_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Storage is never reset so pattern contents survive an abort.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_seg_start;
    logic [ADDR_W-1:0] r_seg_end;
    logic              r_loop;
    logic              r_busy;
    logic              r_ptn_valid;
    logic [DATA_W-1:0] r_ptn_data;
    logic [ADDR_W-1:0] r_ptn_addr;
    logic              r_done;
    logic [DATA_W-1:0] r_rd_data;

    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_at_end;
    logic              w_rd_bypass;

    assign w_ptr_next  = r_ptr + ADDR_W'(1);
    assign w_at_end    = (r_ptr == r_seg_end);
    assign w_rd_bypass = bus.wr_en && (bus.wr_addr == bus.rd_addr);

    // Host write into the RAM; deliberately active during reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Host read port, write-first: a same-address write is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= {DATA_W{1'b0}};
        end else if (bus.rd_en) begin
            if (w_rd_bypass) begin
                r_rd_data <= bus.wr_data;
            end else begin
                r_rd_data <= r_mem[bus.rd_addr];
            end
        end
    end

    // Playback FSM with registered outputs; the RAM read here sees the
    // pre-write contents, giving read-first behaviour on this port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= {ADDR_W{1'b0}};
            r_seg_start <= {ADDR_W{1'b0}};
            r_seg_end   <= {ADDR_W{1'b0}};
            r_loop      <= 1'b0;
            r_busy      <= 1'b0;
            r_ptn_valid <= 1'b0;
            r_ptn_data  <= {DATA_W{1'b0}};
            r_ptn_addr  <= {ADDR_W{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_ptn_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_seg_start <= bus.seg_start;
                        r_seg_end   <= bus.seg_end;
                        r_loop      <= bus.loop_en;
                        r_ptr       <= bus.seg_start;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        // Abort: any tick in this cycle is dropped.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.tick) begin
                        r_ptn_valid <= 1'b1;
                        r_ptn_data  <= r_mem[r_ptr];
                        r_ptn_addr  <= r_ptr;
                        if (w_at_end) begin
                            if (r_loop) begin
                                r_ptr <= r_seg_start;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.busy      = r_busy;
    assign bus.ptn_valid = r_ptn_valid;
    assign bus.ptn_data  = r_ptn_data;
    assign bus.ptn_addr  = r_ptn_addr;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_ptn_seq_ram.sv
// Directed bench for ptn_seq_ram with a 16-word RAM (ADDR_W=4) so the
// wrap-through-zero segment can be exercised directly.
module tb_ptn_seq_ram;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ptn_seq_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ptn_seq_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic host_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        step();
        bus.rd_en = 1'b0;
        chk_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic start_seg(input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic lp, input logic tk);
        bus.seg_start = s; bus.seg_end = e; bus.loop_en = lp;
        bus.start = 1'b1; bus.tick = tk;
        step();
        bus.start = 1'b0;
        chk_eq("start_busy", 32'(bus.busy), 32'd1);
    endtask

    logic [DW-1:0] seq4 [0:3];
    logic [AW-1:0] wrap_a [0:3];
    logic [DW-1:0] wrap_d [0:3];

    initial begin
        n_cmp = 0; n_bad = 0;
        seq4[0] = 16'h1111; seq4[1] = 16'h2222; seq4[2] = 16'h3333; seq4[3] = 16'h4444;
        wrap_a[0] = 4'd14; wrap_a[1] = 4'd15; wrap_a[2] = 4'd0; wrap_a[3] = 4'd1;
        wrap_d[0] = 16'hEEEE; wrap_d[1] = 16'hFFFF; wrap_d[2] = 16'h1111; wrap_d[3] = 16'h2222;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        bus.seg_start = '0; bus.seg_end = '0; bus.tick = 1'b0;

        // Reset, with a host write that must still land.
        rst = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h9999;
        step();
        bus.wr_en = 1'b0;
        step();
        chk_eq("rst_busy",  32'(bus.busy),      32'd0);
        chk_eq("rst_valid", 32'(bus.ptn_valid), 32'd0);
        chk_eq("rst_done",  32'(bus.done),      32'd0);
        chk_eq("rst_data",  32'(bus.ptn_data),  32'd0);
        chk_eq("rst_addr",  32'(bus.ptn_addr),  32'd0);
        chk_eq("rst_rd",    32'(bus.rd_data),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) host_wr(AW'(i), seq4[i]);
        host_wr(4'd5, 16'h0000);
        host_wr(4'd14, 16'hEEEE);
        host_wr(4'd15, 16'hFFFF);
        host_rd(4'd9, 16'h9999, "rd_wr_in_rst");

        // start+stop together stays idle.
        bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk_eq("startstop_idle", 32'(bus.busy), 32'd0);

        // One-shot 0..3, tick held high.
        start_seg(4'd0, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("os_valid", 32'(bus.ptn_valid), 32'd1);
            chk_eq("os_data",  32'(bus.ptn_data),  32'(seq4[i]));
            chk_eq("os_addr",  32'(bus.ptn_addr),  32'(i));
            chk_eq("os_done",  32'(bus.done),      (i == 3) ? 32'd1 : 32'd0);
            chk_eq("os_busy",  32'(bus.busy),      (i == 3) ? 32'd0 : 32'd1);
        end
        step();
        chk_eq("os_after_valid", 32'(bus.ptn_valid), 32'd0);
        chk_eq("os_after_done",  32'(bus.done),      32'd0);
        chk_eq("os_hold_data",   32'(bus.ptn_data),  32'h4444);
        bus.tick = 1'b0;

        // Looped 0..3, ten ticks, then stop with a tick that is dropped.
        start_seg(4'd0, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq("lp_valid", 32'(bus.ptn_valid), 32'd1);
            chk_eq("lp_data",  32'(bus.ptn_data),  32'(seq4[i % 4]));
            chk_eq("lp_busy",  32'(bus.busy),      32'd1);
            chk_eq("lp_done",  32'(bus.done),      32'd0);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0; bus.tick = 1'b0;
        chk_eq("stop_valid", 32'(bus.ptn_valid), 32'd0);
        chk_eq("stop_busy",  32'(bus.busy),      32'd0);
        chk_eq("stop_done",  32'(bus.done),      32'd0);
        chk_eq("stop_hold",  32'(bus.ptn_data),  32'h2222);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk_eq("idle_tick_valid", 32'(bus.ptn_valid), 32'd0);

        // Wrap through zero: segment 14..1 one-shot.
        start_seg(4'd14, 4'd1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("wr_addr", 32'(bus.ptn_addr), 32'(wrap_a[i]));
            chk_eq("wr_data", 32'(bus.ptn_data), 32'(wrap_d[i]));
            chk_eq("wr_done", 32'(bus.done),     (i == 3) ? 32'd1 : 32'd0);
        end
        bus.tick = 1'b0;
        step();

        // Same-cycle write/read/playback at address 5.
        start_seg(4'd5, 4'd5, 1'b0, 1'b0);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
        bus.rd_en = 1'b1; bus.rd_addr = 4'd5; bus.tick = 1'b1;
        step();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.tick = 1'b0;
        chk_eq("wf_rd_data",  32'(bus.rd_data),  32'hBEEF);
        chk_eq("rf_ptn_data", 32'(bus.ptn_data), 32'h0000);
        chk_eq("rf_ptn_addr", 32'(bus.ptn_addr), 32'd5);
        chk_eq("single_done", 32'(bus.done),     32'd1);
        host_rd(4'd2, 16'h3333, "rd_a2");
        step();
        chk_eq("rd_hold", 32'(bus.rd_data), 32'h3333);
        host_rd(4'd5, 16'hBEEF, "rd_a5");

        // Gapped ticks 1-0-0-1, with start and segment inputs wiggled in RUN.
        start_seg(4'd0, 4'd3, 1'b1, 1'b0);
        bus.start = 1'b1; bus.seg_start = 4'd7; bus.seg_end = 4'd9; bus.loop_en = 1'b0;
        bus.tick = 1'b1; step();
        chk_eq("gap0_valid", 32'(bus.ptn_valid), 32'd1);
        chk_eq("gap0_addr",  32'(bus.ptn_addr),  32'd0);
        bus.tick = 1'b0; step();
        chk_eq("gap1_valid", 32'(bus.ptn_valid), 32'd0);
        chk_eq("gap1_hold",  32'(bus.ptn_addr),  32'd0);
        step();
        chk_eq("gap2_valid", 32'(bus.ptn_valid), 32'd0);
        bus.tick = 1'b1; step();
        chk_eq("gap3_valid", 32'(bus.ptn_valid), 32'd1);
        chk_eq("gap3_addr",  32'(bus.ptn_addr),  32'd1);
        chk_eq("gap3_data",  32'(bus.ptn_data),  32'h2222);
        bus.tick = 1'b0; bus.start = 1'b0;
        bus.stop = 1'b1; step(); bus.stop = 1'b0;
        chk_eq("gap_stop_busy", 32'(bus.busy), 32'd0);

        // Reset mid-run at ptr=2.
        start_seg(4'd0, 4'd3, 1'b1, 1'b1);
        step();
        step();
        chk_eq("pre_rst_addr", 32'(bus.ptn_addr), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.tick = 1'b0;
        chk_eq("mrst_busy",  32'(bus.busy),      32'd0);
        chk_eq("mrst_valid", 32'(bus.ptn_valid), 32'd0);
        chk_eq("mrst_data",  32'(bus.ptn_data),  32'd0);
        bus.tick = 1'b1; step(); bus.tick = 1'b0;
        chk_eq("mrst_no_valid", 32'(bus.ptn_valid), 32'd0);
        host_rd(4'd2, 16'h3333, "mrst_ram2");
        host_rd(4'd0, 16'h1111, "mrst_ram0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ptn_seq_ram.md
PTN_SEQ_RAM -- requirements
Module: ptn_seq_ram

Interface
REQ-001 Parameter DATA_W, default 16, pattern word width in bits.
REQ-002 Parameter ADDR_W, default 16, address width; depth SHALL be 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  host write strobe.
REQ-006 wr_addr  input  ADDR_W  host write address.
REQ-007 wr_data  input  DATA_W  host write data.
REQ-008 rd_en  input  1  host read strobe.
REQ-009 rd_addr  input  ADDR_W  host read address.
REQ-010 rd_data  output  DATA_W  host read data, registered.
REQ-011 start  input  1  playback start pulse.
REQ-012 stop  input  1  playback abort pulse.
REQ-013 loop_en  input  1  1 = repeat segment, 0 = one-shot.
REQ-014 seg_start  input  ADDR_W  first playback address.
REQ-015 seg_end  input  ADDR_W  last playback address, inclusive.
REQ-016 tick  input  1  advance playback by one word.
REQ-017 busy  output  1  high while FSM is in RUN.
REQ-018 ptn_valid  output  1  one-cycle strobe qualifying ptn_data and ptn_addr.
REQ-019 ptn_data  output  DATA_W  played pattern word.
REQ-020 ptn_addr  output  ADDR_W  address of the word on ptn_data.
REQ-021 done  output  1  one-cycle pulse at the end of one-shot playback.

Function
REQ-022 Host write: when wr_en=1, RAM[wr_addr] SHALL take wr_data at the clock edge.
REQ-023 Host read: when rd_en=1, rd_data SHALL show RAM[rd_addr] one cycle later; rd_data holds its value when rd_en=0.
REQ-024 Host read port SHALL be write-first: if wr_en=1, rd_en=1 and wr_addr==rd_addr, rd_data SHALL equal wr_data.
REQ-025 Playback read port SHALL be read-first: a host write to the playback address in the same cycle returns the old word.
REQ-026 The FSM SHALL have two states, IDLE and RUN.
REQ-027 IDLE -> RUN on start=1 and stop=0: seg_start, seg_end and loop_en are latched and ptr is set to seg_start.
REQ-028 In RUN, start SHALL be ignored and latched segment values SHALL be unaffected by input changes.
REQ-029 In RUN with tick=1 and stop=0: RAM[ptr] and ptr SHALL appear on ptn_data/ptn_addr with ptn_valid=1 exactly one cycle later.
REQ-030 Pointer advance SHALL be ptr+1 modulo 2**ADDR_W; seg_start > seg_end SHALL therefore wrap through address 0.
REQ-031 tick at ptr==seg_end with loop=1: ptr SHALL reload seg_start and the FSM SHALL stay in RUN.
REQ-032 tick at ptr==seg_end with loop=0: FSM -> IDLE, and done SHALL pulse in the same cycle as the final ptn_valid.
REQ-033 seg_start==seg_end SHALL play a single word, repeated when loop=1.
REQ-034 tick=0 in RUN SHALL hold ptr; ptn_valid=0 in the following cycle.
REQ-035 stop=1 in RUN: FSM -> IDLE and a tick in the same cycle is discarded; ptn_valid, done=0 next cycle; a read already issued still completes.
REQ-036 start and stop asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-037 ptn_data and ptn_addr SHALL hold their last values when ptn_valid=0.
REQ-038 busy SHALL be 1 exactly while the state is RUN.

Reset
REQ-039 rst=1 SHALL force IDLE and clear busy, ptn_valid, done, ptn_data, ptn_addr, rd_data and ptr to 0 at the next edge.
REQ-040 rst SHALL override start, stop and tick in the same cycle; rst in RUN aborts with no further ptn_valid.
REQ-041 RAM contents SHALL NOT be cleared by reset; writes with wr_en=1 during rst SHALL still take effect.

Verification
REQ-042 Write 0x1111..0x4444 to addresses 0..3; start with seg 0..3, loop=0, tick held high -> ptn_data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; done with 0x4444; busy falls.
REQ-043 Same segment with loop=1 and 10 ticks -> sequence 1,2,3,4,1,2,3,4,1,2 (x0x1111 pattern); busy stays 1 until stop; no ptn_valid after stop.
REQ-044 ADDR_W=4, seg 14..1, loop=0 -> ptn_addr 14,15,0,1; done with address 1.
REQ-045 wr_en and rd_en together at addr 5 with data 0xBEEF (old 0x0000) -> rd_data 0xBEEF next cycle; playback of addr 5 in the same cycle returns 0x0000.
REQ-046 Ticks gapped 1-0-0-1 -> ptn_valid 1-0-0-1 with the address advancing only on ticks; start during RUN ignored.
REQ-047 rst mid-RUN at ptr=2 -> next cycle busy=0, ptn_valid=0, ptn_data=0; RAM readback is unchanged.
